// File: rtl/addertree_stage3_acc.sv
// addertree_stage3_acc: resolves stage2 column bits (cols 3..19) and accumulates beats into one result per packet
// Ports: clk/reset (sync, active-high); in_valid/in_last/in_ready + i3..i19 column bits in;
// out_valid/out_ready handshake with out_data (packet sum), out_count (beats), out_overflow (sticky carry-out).
module addertree_stage3_acc #(
  parameter int ACC_W = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             i19,
  input  logic [2:0]       i18,
  input  logic [2:0]       i17,
  input  logic [3:0]       i16,
  input  logic [3:0]       i15,
  input  logic [3:0]       i14,
  input  logic [3:0]       i13,
  input  logic [3:0]       i12,
  input  logic [3:0]       i11,
  input  logic [3:0]       i10,
  input  logic [3:0]       i9,
  input  logic [3:0]       i8,
  input  logic [3:0]       i7,
  input  logic [2:0]       i6,
  input  logic [2:0]       i5,
  input  logic [1:0]       i4,
  input  logic             i3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t r_state, w_state_nxt;
  logic [3:0] w_col [3:19];
  logic [18:0] w_s;
  logic [ACC_W-1:0] w_v, r_sa_val, r_acc, w_acc_nxt, w_sum;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic r_sa_valid, r_sa_last, r_ovf, w_ovf_nxt, w_carry, w_accept, w_load;
  assign w_col[3]  = {3'b0, i3};
  assign w_col[4]  = {2'b0, i4};
  assign w_col[5]  = {1'b0, i5};
  assign w_col[6]  = {1'b0, i6};
  assign w_col[7]  = i7;
  assign w_col[8]  = i8;
  assign w_col[9]  = i9;
  assign w_col[10] = i10;
  assign w_col[11] = i11;
  assign w_col[12] = i12;
  assign w_col[13] = i13;
  assign w_col[14] = i14;
  assign w_col[15] = i15;
  assign w_col[16] = i16;
  assign w_col[17] = {1'b0, i17};
  assign w_col[18] = {1'b0, i18};
  assign w_col[19] = {3'b0, i19};
  always_comb begin
    w_s = '0;
    for (int k = 3; k <= 19; k++)
      w_s = w_s + ((19'(w_col[k][0]) + 19'(w_col[k][1]) + 19'(w_col[k][2]) + 19'(w_col[k][3])) << (k - 3));
  end
  // column 3 carries weight 8 in the full product
  assign w_v = ACC_W'({w_s, 3'b000});
  // a queued last beat blocks intake so nothing follows it into stage A before the result drains
  assign in_ready = (r_state != HOLD) && !(r_sa_valid && r_sa_last);
  assign w_accept = in_valid && in_ready;
  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_sa_val};
  assign out_valid = r_state == HOLD;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sa_valid <= 1'b0;
      r_sa_val   <= '0;
      r_sa_last  <= 1'b0;
    end else begin
      r_sa_valid <= w_accept;
      if (w_accept) begin
        r_sa_val  <= w_v;
        r_sa_last <= in_last;
      end
    end
  end
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_ovf_nxt   = r_ovf;
    if (r_state == HOLD) begin
      if (out_ready) begin
        w_state_nxt = IDLE;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_ovf_nxt   = 1'b0;
      end
    end else if (r_sa_valid) begin
      w_acc_nxt   = (r_state == IDLE) ? r_sa_val : w_sum;
      w_cnt_nxt   = (r_state == IDLE) ? CNT_W'(1) : (&r_cnt ? r_cnt : r_cnt + CNT_W'(1));
      w_ovf_nxt   = (r_state == IDLE) ? 1'b0 : (r_ovf | w_carry);
      w_state_nxt = r_sa_last ? HOLD : ACCUM;
    end
  end
  assign w_load = (r_state != HOLD) && (w_state_nxt == HOLD);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ovf        <= 1'b0;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ovf   <= w_ovf_nxt;
      if (w_load) begin
        out_data     <= w_acc_nxt;
        out_count    <= w_cnt_nxt;
        out_overflow <= w_ovf_nxt;
      end
    end
  end
endmodule

// File: tb/tb_addertree_stage3_acc.sv
// tb_addertree_stage3_acc: scoreboard bench driving a 32-bit and a 22-bit accumulator from one stimulus stream
module tb_addertree_stage3_acc;
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic i19, i3;
  logic [2:0] i18, i17, i6, i5;
  logic [3:0] i16, i15, i14, i13, i12, i11, i10, i9, i8, i7;
  logic [1:0] i4;
  logic in_ready, out_valid, out_overflow;
  logic [31:0] out_data;
  logic [7:0] out_count;
  logic rdy22, ov22, o22;
  logic [21:0] d22;
  logic [7:0] c22;
  typedef struct {
    logic [31:0] d32;
    logic [21:0] d22;
    logic [7:0]  cnt;
    logic        o32;
    logic        o22;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, last_acc = -100;
  logic [31:0] m32 = 0;
  logic [21:0] m22 = 0;
  logic [7:0] mcnt = 0;
  logic mo32 = 0, mo22 = 0, prev_ov = 0;
  addertree_stage3_acc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .i19(i19), .i18(i18), .i17(i17), .i16(i16), .i15(i15), .i14(i14), .i13(i13), .i12(i12),
    .i11(i11), .i10(i10), .i9(i9), .i8(i8), .i7(i7), .i6(i6), .i5(i5), .i4(i4), .i3(i3),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_overflow(out_overflow)
  );
  addertree_stage3_acc #(.ACC_W(22)) dut22 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_last(in_last), .in_ready(rdy22),
    .i19(i19), .i18(i18), .i17(i17), .i16(i16), .i15(i15), .i14(i14), .i13(i13), .i12(i12),
    .i11(i11), .i10(i10), .i9(i9), .i8(i8), .i7(i7), .i6(i6), .i5(i5), .i4(i4), .i3(i3),
    .out_valid(ov22), .out_ready(out_ready), .out_data(d22), .out_count(c22),
    .out_overflow(o22)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic cols(input bit ones);
    {i19, i18, i17, i16, i15, i14, i13, i12, i11, i10, i9, i8, i7, i6, i5, i4, i3} = {56{ones}};
  endtask
  function automatic int model_s();
    return $countones(i3) + 2 * $countones(i4) + 4 * $countones(i5) + 8 * $countones(i6)
      + 16 * $countones(i7) + 32 * $countones(i8) + 64 * $countones(i9) + 128 * $countones(i10)
      + 256 * $countones(i11) + 512 * $countones(i12) + 1024 * $countones(i13)
      + 2048 * $countones(i14) + 4096 * $countones(i15) + 8192 * $countones(i16)
      + 16384 * $countones(i17) + 32768 * $countones(i18) + 65536 * $countones(i19);
  endfunction
  task automatic model_clear();
    m32 = 0; m22 = 0; mcnt = 0; mo32 = 0; mo22 = 0;
  endtask
  task automatic send(input bit last);
    int n;
    logic [32:0] t32;
    logic [22:0] t22;
    in_valid = 1;
    in_last = last;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else begin
      t32 = {1'b0, m32} + 33'(model_s() * 8);
      t22 = {1'b0, m22} + 23'(model_s() * 8);
      m32 = t32[31:0]; mo32 |= t32[32];
      m22 = t22[21:0]; mo22 |= t22[22];
      mcnt = (mcnt == 8'hff) ? mcnt : mcnt + 8'd1;
      last_acc = last ? cyc : last_acc;
      if (last) begin
        q.push_back('{d32: m32, d22: m22, cnt: mcnt, o32: mo32, o22: mo22});
        model_clear();
      end
    end
    @(posedge clk);
    #1;
    in_valid = 0;
    in_last = 0;
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (cyc == last_acc + 1) chk("rdy_drop", {31'b0, in_ready}, 0);
      if (out_valid && !prev_ov) chk("latency", cyc - last_acc, 2);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("spurious", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("data32", out_data, e.d32);
          chk("count", {24'b0, out_count}, {24'b0, e.cnt});
          chk("ovf32", {31'b0, out_overflow}, {31'b0, e.o32});
          chk("valid22", {31'b0, ov22}, 1);
          chk("data22", {10'b0, d22}, {10'b0, e.d22});
          chk("count22", {24'b0, c22}, {24'b0, e.cnt});
          chk("ovf22", {31'b0, o22}, {31'b0, e.o22});
        end
      end
    end
    prev_ov = out_valid;
  end
  initial begin
    int hc;
    cols(0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_ready", {31'b0, in_ready}, 1);
    chk("rst_valid", {31'b0, out_valid}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", {24'b0, out_count}, 0);
    chk("rst_ovf", {31'b0, out_overflow}, 0);
    @(posedge clk); #1;
    cols(0); i3 = 1;
    send(1);
    chk("model_i3", m32 + q[0].d32, 8);
    cols(1);
    send(1);
    chk("model_ones", q[q.size()-1].d32, 2228040);
    cols(0); i7 = 4'b0001;
    send(0); send(0); send(1);
    chk("model_3beat", q[q.size()-1].d32, 384);
    repeat (3) @(negedge clk);
    chk("rdy_back", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    out_ready = 0;
    cols(0); i3 = 1;
    send(1);
    cols(0); i5 = 3'b111;
    fork
      send(1);
      begin
        @(negedge clk);
        while (!out_valid) @(negedge clk);
        repeat (5) begin
          chk("bp_valid", {31'b0, out_valid}, 1);
          chk("bp_data", out_data, 8);
          chk("bp_count", {24'b0, out_count}, 1);
          chk("bp_ready", {31'b0, in_ready}, 0);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1;
        hc = cyc;
      end
    join
    chk("bp_accept_cyc", last_acc, hc + 1);
    repeat (4) @(posedge clk); #1;
    cols(1);
    send(0); send(1);
    cols(0); i3 = 1;
    send(1);
    repeat (4) @(posedge clk); #1;
    cols(0); i7 = 4'b1111;
    send(0); send(0);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    model_clear();
    @(negedge clk);
    chk("rst_mid_ready", {31'b0, in_ready}, 1);
    @(posedge clk); #1;
    cols(0); i4 = 2'b11;
    send(1);
    repeat (10) @(posedge clk);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end
endmodule
